// File: rtl/repetition_ecc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : repetition_ecc_pkg
//  Description : Shared defaults and FSM state type for the repetition-code
//                stream decoder and its group accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package repetition_ecc_pkg;

    localparam int c_default_data_width        = 8;
    localparam int c_default_repetition_factor = 3;

    // COLLECT: accepting serial samples; HOLD: presenting a decoded word.
    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/repetition_group_accum.sv
`default_nettype none
// ============================================================================
//  Module      : repetition_group_accum
//  Description : Running ones count for one repetition group. The vote and
//                disagreement flag reflect the count including the sample
//                currently offered, so they are valid on the group's last
//                sample without an extra cycle.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                i_sample_en        - a sample is consumed this cycle
//                i_group_start      - the offered sample is sample 0 of a group
//                i_sample_bit       - offered sample value
//                o_vote             - majority of the group so far
//                o_disagree         - group contains both zeros and ones
//  Revision    : 1.0 - initial release
// ============================================================================
module repetition_group_accum
    import repetition_ecc_pkg::*;
#(
    parameter int REPETITION_FACTOR = c_default_repetition_factor
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sample_en,
    input  logic i_group_start,
    input  logic i_sample_bit,
    output logic o_vote,
    output logic o_disagree
);

    // Wide enough to hold REPETITION_FACTOR, so the count never overflows.
    localparam int c_ones_w = $clog2(REPETITION_FACTOR + 1);

    logic [c_ones_w-1:0] r_ones_q;
    logic [c_ones_w-1:0] w_ones_d;
    logic [c_ones_w-1:0] w_ones_total;

    always_comb begin
        w_ones_total = (i_group_start ? '0 : r_ones_q) + c_ones_w'(i_sample_bit);
        w_ones_d     = r_ones_q;
        if (i_sample_en) begin
            w_ones_d = w_ones_total;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ones_q <= '0;
        end else begin
            r_ones_q <= w_ones_d;
        end
    end

    assign o_vote     = (w_ones_total > c_ones_w'(REPETITION_FACTOR / 2));
    assign o_disagree = (w_ones_total != '0) &&
                        (w_ones_total != c_ones_w'(REPETITION_FACTOR));

endmodule
`default_nettype wire

// File: rtl/repetition_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : repetition_stream_decoder
//  Description : Collects a serial stream of repeated samples (LSB-first,
//                REPETITION_FACTOR samples per data bit), majority-votes each
//                group and presents the decoded word with a valid/ready
//                handshake. in_sof resynchronises to sample 0 of bit 0.
//  Ports       : clk, rst                    - clock, sync active-high reset
//                in_valid/in_ready/in_bit    - serial sample handshake
//                in_sof                      - first sample of a new word
//                out_valid/out_ready         - decoded word handshake
//                out_data                    - majority-voted word
//                error_detected              - any group had disagreement
//                corrected_groups            - number of disagreeing groups
//                err_clear/err_count         - optional saturating counter of
//                                              corrected groups, present only
//                                              when REPETITION_STREAM_ERR_CNT_EN
//                                              is defined
//  Revision    : 1.0 - initial release
// ============================================================================
module repetition_stream_decoder
    import repetition_ecc_pkg::*;
#(
    parameter int DATA_WIDTH        = c_default_data_width,
    parameter int REPETITION_FACTOR = c_default_repetition_factor
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            in_bit,
    input  logic                            in_sof,
    output logic                            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            error_detected,
    output logic [$clog2(DATA_WIDTH+1)-1:0] corrected_groups
`ifdef REPETITION_STREAM_ERR_CNT_EN
    ,
    input  logic                            err_clear,
    output logic [15:0]                     err_count
`endif
);

    localparam int c_samp_w = $clog2(REPETITION_FACTOR);
    localparam int c_bit_w  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int c_corr_w = $clog2(DATA_WIDTH + 1);

    state_t                r_state_q,    w_state_d;
    logic [c_samp_w-1:0]   r_samp_q,     w_samp_d;
    logic [c_bit_w-1:0]    r_bit_q,      w_bit_d;
    logic [DATA_WIDTH-1:0] r_acc_data_q, w_acc_data_d;
    logic [c_corr_w-1:0]   r_acc_corr_q, w_acc_corr_d;
    logic [DATA_WIDTH-1:0] r_out_data_q, w_out_data_d;
    logic                  r_err_q,      w_err_d;
    logic [c_corr_w-1:0]   r_corr_q,     w_corr_d;

    logic                  w_hs;
    logic [c_samp_w-1:0]   w_eff_samp;
    logic [c_bit_w-1:0]    w_eff_bit;
    logic                  w_group_start;
    logic                  w_group_end;
    logic                  w_word_end;
    logic                  w_word_done;
    logic                  w_vote;
    logic                  w_disagree;
    logic [DATA_WIDTH-1:0] w_word;
    logic [c_corr_w-1:0]   w_corr;

    assign in_ready  = !rst && (r_state_q == ST_COLLECT);
    assign out_valid = !rst && (r_state_q == ST_HOLD);
    assign w_hs      = in_valid && in_ready;

    // A start-of-frame sample restarts the word at sample 0 of bit 0,
    // even when it lands on what would otherwise be the final position.
    assign w_eff_samp    = in_sof ? '0 : r_samp_q;
    assign w_eff_bit     = in_sof ? '0 : r_bit_q;
    assign w_group_start = (w_eff_samp == '0);
    assign w_group_end   = (w_eff_samp == c_samp_w'(REPETITION_FACTOR - 1));
    assign w_word_end    = w_group_end && (w_eff_bit == c_bit_w'(DATA_WIDTH - 1));
    assign w_word_done   = w_hs && w_word_end;

    repetition_group_accum #(
        .REPETITION_FACTOR (REPETITION_FACTOR)
    ) u_group_accum (
        .clk           (clk),
        .rst           (rst),
        .i_sample_en   (w_hs),
        .i_group_start (w_group_start),
        .i_sample_bit  (in_bit),
        .o_vote        (w_vote),
        .o_disagree    (w_disagree)
    );

    // Word and correction count including the group that closes this cycle.
    // Stale high bits from an earlier word are always overwritten before the
    // word completes, so the partial accumulator needs no clearing.
    always_comb begin
        w_word            = r_acc_data_q;
        w_word[w_eff_bit] = w_vote;
        w_corr            = ((w_eff_bit == '0) ? '0 : r_acc_corr_q) + c_corr_w'(w_disagree);
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_samp_d     = r_samp_q;
        w_bit_d      = r_bit_q;
        w_acc_data_d = r_acc_data_q;
        w_acc_corr_d = r_acc_corr_q;
        w_out_data_d = r_out_data_q;
        w_err_d      = r_err_q;
        w_corr_d     = r_corr_q;
        case (r_state_q)
            ST_COLLECT: begin
                if (w_hs) begin
                    if (w_group_end) begin
                        w_acc_data_d = w_word;
                        w_acc_corr_d = w_corr;
                        w_samp_d     = '0;
                        if (w_word_end) begin
                            w_bit_d      = '0;
                            w_out_data_d = w_word;
                            w_err_d      = (w_corr != '0);
                            w_corr_d     = w_corr;
                            w_state_d    = ST_HOLD;
                        end else begin
                            w_bit_d = w_eff_bit + c_bit_w'(1);
                        end
                    end else begin
                        w_samp_d = w_eff_samp + c_samp_w'(1);
                        w_bit_d  = w_eff_bit;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_d = ST_COLLECT;
                end
            end
            default: w_state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_COLLECT;
            r_samp_q     <= '0;
            r_bit_q      <= '0;
            r_acc_data_q <= '0;
            r_acc_corr_q <= '0;
            r_out_data_q <= '0;
            r_err_q      <= 1'b0;
            r_corr_q     <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_samp_q     <= w_samp_d;
            r_bit_q      <= w_bit_d;
            r_acc_data_q <= w_acc_data_d;
            r_acc_corr_q <= w_acc_corr_d;
            r_out_data_q <= w_out_data_d;
            r_err_q      <= w_err_d;
            r_corr_q     <= w_corr_d;
        end
    end

    assign out_data         = r_out_data_q;
    assign error_detected   = r_err_q;
    assign corrected_groups = r_corr_q;

`ifdef REPETITION_STREAM_ERR_CNT_EN
    logic [15:0] r_err_count_q, w_err_count_d;
    logic [16:0] w_err_sum;

    always_comb begin
        w_err_sum     = {1'b0, r_err_count_q} + 17'(w_corr);
        w_err_count_d = r_err_count_q;
        if (err_clear) begin
            w_err_count_d = '0;
        end else if (w_word_done) begin
            w_err_count_d = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count_q <= '0;
        end else begin
            r_err_count_q <= w_err_count_d;
        end
    end

    assign err_count = r_err_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_repetition_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_repetition_stream_decoder
//  Description : Self-checking bench for repetition_stream_decoder
//                (DATA_WIDTH=8, REPETITION_FACTOR=3). Expected words come from
//                a group-counting reference model over the sample vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_repetition_stream_decoder;

    localparam int DW = 8;
    localparam int RF = 3;
    localparam int N  = DW * RF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          in_sof = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          error_detected;
    logic [3:0]    corrected_groups;
`ifdef REPETITION_STREAM_ERR_CNT_EN
    logic          err_clear = 1'b0;
    logic [15:0]   err_count;
    int            exp_err = 0;
`endif

    int checks   = 0;
    int failures = 0;

    repetition_stream_decoder #(.DATA_WIDTH(DW), .REPETITION_FACTOR(RF)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_bit           (in_bit),
        .in_sof           (in_sof),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .error_detected   (error_detected),
        .corrected_groups (corrected_groups)
`ifdef REPETITION_STREAM_ERR_CNT_EN
        ,
        .err_clear        (err_clear),
        .err_count        (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Repetition-encode a word and xor in a per-sample flip mask.
    function automatic logic [N-1:0] encode(input logic [DW-1:0] data, input logic [N-1:0] flips);
        logic [N-1:0] s;
        for (int i = 0; i < N; i++) s[i] = data[i / RF] ^ flips[i];
        return s;
    endfunction

    // Reference decode: count ones per group, majority vote, count mixed groups.
    task automatic model(input logic [N-1:0] s, output logic [DW-1:0] d, output int corr);
        corr = 0;
        d    = '0;
        for (int b = 0; b < DW; b++) begin
            int ones = 0;
            for (int k = 0; k < RF; k++) ones += int'(s[b*RF + k]);
            d[b] = (2 * ones > RF);
            if (ones != 0 && ones != RF) corr++;
        end
    endtask

    task automatic send_sample(input logic b, input logic sof);
        in_valid = 1'b1;
        in_bit   = b;
        in_sof   = sof;
        tick();
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] s, input logic use_sof, input int max_gap);
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            send_sample(s[i], use_sof && (i == 0));
        end
    endtask

    task automatic expect_word(input string tag, input logic [N-1:0] s);
        logic [DW-1:0] d;
        int            corr;
        model(s, d, corr);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".out_data"}, 32'(out_data), 32'(d));
        check({tag, ".error_detected"}, 32'(error_detected), 32'(corr != 0));
        check({tag, ".corrected_groups"}, 32'(corrected_groups), 32'(corr));
`ifdef REPETITION_STREAM_ERR_CNT_EN
        exp_err = (exp_err + corr > 65535) ? 65535 : exp_err + corr;
        check({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
`endif
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_data"}, 32'(out_data), 32'd0);
        check({tag, ".error_detected"}, 32'(error_detected), 32'd0);
        check({tag, ".corrected_groups"}, 32'(corrected_groups), 32'd0);
    endtask

    initial begin
        logic [N-1:0] s, s2, fl;
        logic [DW-1:0] held;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("reset.release_in_ready", 32'(in_ready), 32'd1);

        // Clean 0xA5, no sof: out_valid right after the 24th handshake
        s = encode(8'hA5, '0);
        send_word(s, 1'b0, 0);
        check("clean.in_ready_hold", 32'(in_ready), 32'd0);
        expect_word("clean", s);
        accept("clean");

        // One flipped sample in bit 0 and in bit 7
        fl = '0;
        fl[1] = 1'b1;
        fl[22] = 1'b1;
        s = encode(8'hA5, fl);
        send_word(s, 1'b0, 0);
        expect_word("flips", s);
        accept("flips");

        // Backpressure: samples offered in HOLD must not be consumed
        s = encode(8'h96, '0);
        send_word(s, 1'b1, 1);
        expect_word("bp", s);
        held = out_data;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom);
            in_sof   = 1'($urandom);
            tick();
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.out_data", 32'(out_data), 32'(held));
            check("bp.in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        accept("bp");
        s = encode(8'h5A, '0);
        send_word(s, 1'b0, 0);
        expect_word("bp_after", s);
        accept("bp_after");

        // Resync: 10 stray samples, then sof + 0x3C
        for (int i = 0; i < 10; i++) send_sample(1'($urandom), 1'b0);
        s = encode(8'h3C, '0);
        send_word(s, 1'b1, 0);
        expect_word("resync", s);
        accept("resync");
        tick();
        check("resync.single_word", 32'(out_valid), 32'd0);

        // sof on the final sample position restarts the word
        s  = encode(8'hC3, '0);
        s2 = encode(8'h81, '0);
        for (int i = 0; i < N - 1; i++) send_sample(s[i], 1'b0);
        send_sample(s2[0], 1'b1);
        check("sof_last.no_word", 32'(out_valid), 32'd0);
        for (int i = 1; i < N; i++) send_sample(s2[i], 1'b0);
        expect_word("sof_last", s2);
        accept("sof_last");

        // Reset mid-word, then a full 0xFF
        for (int i = 0; i < 7; i++) send_sample(1'b1, 1'b0);
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        rst = 1'b0;
`ifdef REPETITION_STREAM_ERR_CNT_EN
        exp_err = 0;
`endif
        s = encode(8'hFF, '0);
        send_word(s, 1'b0, 0);
        expect_word("rst_mid_ff", s);

        // Reset while holding a word discards it
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        #1;
        check("rst_hold.in_ready", 32'(in_ready), 32'd1);

        // Randomised words against the reference model
        for (int w = 0; w < 16; w++) begin
            for (int i = 0; i < N; i++) fl[i] = ($urandom_range(5, 0) == 0);
            s = encode(DW'($urandom), fl);
            send_word(s, 1'($urandom), 2);
            expect_word($sformatf("rand%0d", w), s);
            held = out_data;
            repeat ($urandom_range(3, 0)) tick();
            check($sformatf("rand%0d.stable", w), 32'(out_data), 32'(held));
            accept($sformatf("rand%0d", w));
        end

`ifdef REPETITION_STREAM_ERR_CNT_EN
        // Error counter: clear, three single-flip words, clear, saturation
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        exp_err = 0;
        check("errcnt.clear0", 32'(err_count), 32'd0);
        for (int w = 0; w < 3; w++) begin
            fl = '0;
            fl[$urandom_range(N - 1, 0)] = 1'b1;
            s = encode(DW'($urandom), fl);
            send_word(s, 1'b0, 0);
            expect_word("errcnt", s);
            accept("errcnt");
        end
        check("errcnt.three", 32'(err_count), 32'd3);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        exp_err = 0;
        check("errcnt.clear", 32'(err_count), 32'd0);
        dut.r_err_count_q = 16'hFFFC;
        exp_err = 32'hFFFC;
        fl = '0;
        for (int b = 0; b < DW; b++) fl[b*RF] = 1'b1;
        for (int w = 0; w < 2; w++) begin
            s = encode(DW'($urandom), fl);
            send_word(s, 1'b0, 0);
            expect_word("errcnt.sat", s);
            accept("errcnt.sat");
        end
        check("errcnt.saturated", 32'(err_count), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/repetition_stream_decoder.md
REPETITION_STREAM_DECODER -- requirements
Module: repetition_stream_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning decoded word width in bits.
REQ-002 SHALL have parameter REPETITION_FACTOR, default 3, meaning serial samples per data bit; odd and >= 3.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  serial sample offered.
REQ-006 SHALL have port in_bit  input  1  serial sample value.
REQ-007 SHALL have port in_sof  input  1  qualified by in_valid; marks the first sample of a new word.
REQ-008 SHALL have port in_ready  output  1  decoder accepts a sample this cycle.
REQ-009 SHALL have port out_valid  output  1  decoded word available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  majority-voted word.
REQ-012 SHALL have port error_detected  output  1  at least one group in out_data had disagreeing samples.
REQ-013 SHALL have port corrected_groups  output  $clog2(DATA_WIDTH+1)  number of groups in out_data with disagreeing samples.

Function
REQ-014 SHALL accept a sample only when in_valid && in_ready (a sample handshake).
REQ-015 SHALL treat samples LSB-first: samples 0..RF-1 form bit 0, the next RF form bit 1, up to bit DATA_WIDTH-1.
REQ-016 SHALL decode each bit as 1 iff the count of ones in its group > REPETITION_FACTOR/2 (integer division).
REQ-017 SHALL count a group as corrected when 0 < ones < REPETITION_FACTOR.
REQ-018 SHALL implement FSM states COLLECT (in_ready=1) and HOLD (in_ready=0, out_valid=1).
REQ-019 SHALL, on the handshake of sample DATA_WIDTH*RF-1 in COLLECT, register out_data, error_detected and corrected_groups, and enter HOLD; out_valid rises the next cycle.
REQ-020 SHALL, in HOLD, keep out_data, error_detected and corrected_groups stable until out_valid && out_ready, then return to COLLECT with out_valid=0 the next cycle.
REQ-021 SHALL ignore in_valid, in_bit and in_sof while in HOLD.
REQ-022 SHALL, on an in_sof sample handshake, discard any partial word and treat that sample as sample 0 of bit 0.
REQ-023 SHALL treat in_sof on the final sample position as sample 0, so no word completes that cycle.
REQ-024 SHALL keep sample and bit counters that wrap to 0 after the last sample of a word.
REQ-025 SHALL keep the running per-group ones count at $clog2(RF+1) bits, which cannot overflow.

Reset
REQ-026 SHALL, while rst=1, set state=COLLECT, both counters=0, out_valid=0, out_data=0, error_detected=0 and corrected_groups=0.
REQ-027 SHALL, when rst asserts mid-word or in HOLD, discard the partial or held word without emitting it.
REQ-028 SHALL drive in_ready=0 during reset.

Configuration
REQ-029 SHALL, when macro REPETITION_STREAM_ERR_CNT_EN is defined, add input err_clear (1) and output err_count (16).
REQ-030 With the macro, err_count SHALL add corrected_groups of each completed word, saturate at 0xFFFF, reset to 0 on rst, and clear to 0 on err_clear; err_clear SHALL win over a simultaneous word completion.
REQ-031 Without the macro, these ports and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-032 SHALL place default DATA_WIDTH/REPETITION_FACTOR constants and the FSM state enum in shared package repetition_ecc_pkg.
REQ-033 SHALL instantiate one sub-module, repetition_group_accum, which counts the ones in one group and outputs the voted bit and the disagreement flag.

Verification (DATA_WIDTH=8, RF=3)
REQ-034 Clean 0xA5: send 24 clean samples -> out_valid one cycle after the 24th handshake, out_data=0xA5, error_detected=0, corrected_groups=0.
REQ-035 Single flips: 0xA5 with one sample flipped in bit 0 and bit 7 -> out_data=0xA5, error_detected=1, corrected_groups=2.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles after a word completes -> out_valid and out_data stay stable, in_ready=0, offered samples are not consumed.
REQ-037 Resync: send 10 samples, then in_sof and 24 samples encoding 0x3C -> exactly one word, out_data=0x3C.
REQ-038 Reset: assert rst after 7 samples -> all outputs 0; then 24 samples for 0xFF -> out_data=0xFF.
REQ-039 Error counter (macro on): three words each with one flip -> err_count=3; pulse err_clear -> 0; preload near 0xFFFF -> err_count saturates at 0xFFFF.
